// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encodings and counter-width derivation for universal_shift_reg.
package universal_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } sr_mode_e;

    // Never return zero so a 1-bit counter still exists at the minimum width.
    function automatic int cnt_w_f(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/univ_sr_frame_counter.sv
// Counts shifts since the last load and pulses frame_done after the WIDTH-th shift.
module univ_sr_frame_counter
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_w_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (clear) begin
                cnt_d = '0;
            end else if (step) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt  = cnt_q;
    assign frame_done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load with frame counter.
// Defining UNIV_SR_ROTATE_EN adds the rot port, turning shifts into rotates.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_w_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
`ifdef UNIV_SR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             fill_r, fill_l;
    logic             step, clear;
    sr_mode_e         mode_e;

    assign mode_e = sr_mode_e'(mode);

    always_comb begin
        fill_r = ser_in_r;
        fill_l = ser_in_l;
`ifdef UNIV_SR_ROTATE_EN
        if (rot) begin
            fill_r = data_q[0];
            fill_l = data_q[WIDTH-1];
        end
`endif
    end

    always_comb begin
        data_d = data_q;
        step   = 1'b0;
        clear  = 1'b0;
        if (en) begin
            case (mode_e)
                MODE_SHR: begin
                    data_d = {fill_r, data_q[WIDTH-1:1]};
                    step   = 1'b1;
                end
                MODE_SHL: begin
                    data_d = {data_q[WIDTH-2:0], fill_l};
                    step   = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = data_in;
                    clear  = 1'b1;
                end
                default: data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    univ_sr_frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .step      (step),
        .shift_cnt (shift_cnt),
        .frame_done(frame_done)
    );

    assign data_out  = data_q;
    assign ser_out_r = data_q[0];
    assign ser_out_l = data_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=4; rotate scenario only with UNIV_SR_ROTATE_EN.
module tb_universal_shift_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, ser_in_r, ser_in_l;
    logic [1:0]   mode;
    logic [W-1:0] data_in;
    logic         rot;
    logic [W-1:0] data_out;
    logic         ser_out_r, ser_out_l, frame_done;
    logic [1:0]   shift_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .data_in   (data_in),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
`ifdef UNIV_SR_ROTATE_EN
        .rot       (rot),
`endif
        .data_out  (data_out),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
        .frame_done(frame_done)
    );

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        en = 1'b1; mode = 2'b11; data_in = v;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 2'b00; data_in = '0;
        ser_in_r = 1'b0; ser_in_l = 1'b0; rot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset = 1'b0;
            tick();
            checks++;
            if ({data_out, shift_cnt, frame_done} !== 7'b0000_00_0) begin
                failures++;
                $display("FAIL reset cyc%0d got data=%b cnt=%0d fd=%b want data=0000 cnt=0 fd=0",
                         i, data_out, shift_cnt, frame_done);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [W-1:0] exp_d [5] = '{4'b1011, 4'b0101, 4'b0010, 4'b0001, 4'b0000};
        logic [1:0]   exp_c [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic         exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         exp_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_load(4'b1011);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                mode = 2'b01; ser_in_r = 1'b0;
                tick();
            end
            checks++;
            if ({data_out, shift_cnt, frame_done} !== {exp_d[i], exp_c[i], exp_f[i]}) begin
                failures++;
                $display("FAIL shr step%0d got data=%b cnt=%0d fd=%b want data=%b cnt=%0d fd=%b",
                         i, data_out, shift_cnt, frame_done, exp_d[i], exp_c[i], exp_f[i]);
            end
            if (i < 4) begin
                checks++;
                if (ser_out_r !== exp_s[i] || ser_out_l !== exp_d[i][W-1]) begin
                    failures++;
                    $display("FAIL shr_serout step%0d got r=%b l=%b want r=%b l=%b",
                             i, ser_out_r, ser_out_l, exp_s[i], exp_d[i][W-1]);
                end
            end
        end
        mode = 2'b00;
        tick();
        checks++;
        if ({data_out, shift_cnt, frame_done} !== 7'b0000_00_0) begin
            failures++;
            $display("FAIL shr_pulse_end got data=%b cnt=%0d fd=%b want data=0000 cnt=0 fd=0",
                     data_out, shift_cnt, frame_done);
        end
    endtask

    task automatic test_shift_left_reload();
        logic [W-1:0] exp_d [3] = '{4'b0011, 4'b0111, 4'b1111};
        do_load(4'b0001);
        for (int i = 0; i < 3; i++) begin
            mode = 2'b10; ser_in_l = 1'b1;
            tick();
            checks++;
            if ({data_out, shift_cnt, frame_done} !== {exp_d[i], 2'(i + 1), 1'b0}) begin
                failures++;
                $display("FAIL shl step%0d got data=%b cnt=%0d fd=%b want data=%b cnt=%0d fd=0",
                         i, data_out, shift_cnt, frame_done, exp_d[i], i + 1);
            end
        end
        checks++;
        if (ser_out_r !== 1'b1 || ser_out_l !== 1'b1) begin
            failures++;
            $display("FAIL shl_serout got r=%b l=%b want r=1 l=1", ser_out_r, ser_out_l);
        end
        do_load(4'b0110);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({data_out, shift_cnt, frame_done} !== 7'b0110_00_0) begin
                failures++;
                $display("FAIL reload cyc%0d got data=%b cnt=%0d fd=%b want data=0110 cnt=0 fd=0",
                         i, data_out, shift_cnt, frame_done);
            end
            mode = 2'b00;
            tick();
        end
    endtask

    task automatic test_enable_pause();
        logic [W-1:0] exp_d [7] = '{4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        logic [1:0]   exp_c [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        logic         exp_f [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_load(4'b1001);
        for (int i = 0; i < 7; i++) begin
            en = !(i >= 2 && i <= 4);
            mode = 2'b01; ser_in_r = 1'b1;
            tick();
            checks++;
            if ({data_out, shift_cnt, frame_done} !== {exp_d[i], exp_c[i], exp_f[i]}) begin
                failures++;
                $display("FAIL en_pause cyc%0d got data=%b cnt=%0d fd=%b want data=%b cnt=%0d fd=%b",
                         i, data_out, shift_cnt, frame_done, exp_d[i], exp_c[i], exp_f[i]);
            end
        end
        en = 1'b1; mode = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        do_load(4'b1100);
        mode = 2'b01; ser_in_r = 1'b0;
        tick();
        tick();
        checks++;
        if ({data_out, shift_cnt} !== 6'b0011_10) begin
            failures++;
            $display("FAIL midrst_pre got data=%b cnt=%0d want data=0011 cnt=2", data_out, shift_cnt);
        end
        reset = 1'b1; mode = 2'b01;
        tick();
        reset = 1'b0; mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({data_out, shift_cnt, frame_done} !== 7'b0000_00_0) begin
                failures++;
                $display("FAIL midrst cyc%0d got data=%b cnt=%0d fd=%b want data=0000 cnt=0 fd=0",
                         i, data_out, shift_cnt, frame_done);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   m     [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
        logic         sin   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] exp_d [5] = '{4'b1000, 4'b0000, 4'b1000, 4'b0001, 4'b0011};
        logic [1:0]   exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic         exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_load(4'b0000);
        for (int i = 0; i < 5; i++) begin
            mode = m[i]; ser_in_r = sin[i]; ser_in_l = sin[i];
            tick();
            checks++;
            if ({data_out, shift_cnt, frame_done} !== {exp_d[i], exp_c[i], exp_f[i]}) begin
                failures++;
                $display("FAIL mixed step%0d got data=%b cnt=%0d fd=%b want data=%b cnt=%0d fd=%b",
                         i, data_out, shift_cnt, frame_done, exp_d[i], exp_c[i], exp_f[i]);
            end
        end
        mode = 2'b00;
        tick();
    endtask

`ifdef UNIV_SR_ROTATE_EN
    task automatic test_rotate();
        logic [W-1:0] exp_d [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        do_load(4'b1000);
        for (int i = 0; i < 4; i++) begin
            mode = 2'b01; rot = 1'b1; ser_in_r = 1'b0;
            tick();
            checks++;
            if ({data_out, frame_done} !== {exp_d[i], i == 3}) begin
                failures++;
                $display("FAIL rotate step%0d got data=%b fd=%b want data=%b fd=%b",
                         i, data_out, frame_done, exp_d[i], i == 3);
            end
        end
        mode = 2'b10; ser_in_l = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'b0001) begin
            failures++;
            $display("FAIL rotate_left got data=%b want data=0001", data_out);
        end
        rot = 1'b0; mode = 2'b00;
        tick();
    endtask
`endif

    initial begin
        rot = 1'b0;
        test_reset();
        test_shift_right();
        test_shift_left_reload();
        test_enable_pause();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UNIV_SR_ROTATE_EN
        test_rotate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
